// File: rtl/note_sequencer.sv
// Note playback sequencer: pulls note words from the song memory, decodes pitch and length, and
// holds each pitch for its timed duration with tempo, pause, stop and end-of-song handling.
module note_sequencer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH_BIT    = 8,
  parameter int unsigned UNIT_TICKS   = 2_500_000,
  parameter int unsigned GAP_TICKS    = 250_000,
  parameter int unsigned READ_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [1:0]            tempo_sel,
  input  logic [DEPTH_BIT-1:0]  song_len,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  mem_read_en,
  output logic                  mem_read_rst,
  output logic [4:0]            note_code,
  output logic                  note_valid,
  output logic [DEPTH_BIT-1:0]  note_idx,
  output logic                  playing,
  output logic                  done
);

  localparam int unsigned TickW = $clog2(UNIT_TICKS * 8 + 1);
  localparam int unsigned WaitW = $clog2(READ_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StRewind, StFetch, StWait, StPlay, StDone} state_e;

  state_e             state_q;
  logic [TickW-1:0]   rem_q;  // ticks left in the current note, this cycle included
  logic [WaitW-1:0]   wait_q;
  logic [4:0]         word_pitch;
  logic [3:0]         word_units;
  logic [TickW-1:0]   word_ticks;
  logic [DEPTH_BIT:0] idx_inc;

  always_comb begin
    word_pitch = mem_data[DATA_WIDTH-1 -: 5];
    word_units = (mem_data[2:0] == 3'd0) ? 4'd8 : {1'b0, mem_data[2:0]};
    word_ticks = TickW'(UNIT_TICKS >> tempo_sel) * TickW'(word_units);
    idx_inc    = {1'b0, note_idx} + (DEPTH_BIT + 1)'(1);
  end

  // Pause mutes in the same cycle; the counter freeze lands on the edge that samples it.
  assign note_valid = (state_q == StPlay) && (note_code != 5'd0) && !pause &&
                      (rem_q > TickW'(GAP_TICKS));
  assign playing    = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      wait_q       <= '0;
      note_code    <= '0;
      note_idx     <= '0;
      mem_read_en  <= 1'b0;
      mem_read_rst <= 1'b0;
      done         <= 1'b0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_read_rst <= 1'b0;
      done         <= 1'b0;
      if (stop && state_q != StIdle) begin
        state_q   <= StIdle;
        note_code <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !stop) begin
              state_q      <= StRewind;
              mem_read_rst <= 1'b1;
            end
          end
          StRewind: begin
            note_idx    <= '0;
            state_q     <= StFetch;
            mem_read_en <= (song_len != '0);
          end
          StFetch: begin
            if (note_idx >= song_len) begin
              state_q   <= StDone;
              done      <= 1'b1;
              note_code <= '0;
            end else begin
              state_q <= StWait;
              wait_q  <= '0;
            end
          end
          StWait: begin
            if (mem_ready) begin
              if (mem_data == '0) begin
                state_q   <= StDone;
                done      <= 1'b1;
                note_code <= '0;
              end else begin
                note_code <= word_pitch;
                rem_q     <= word_ticks;
                state_q   <= StPlay;
              end
            end else if (wait_q == WaitW'(READ_TIMEOUT - 1)) begin
              state_q   <= StDone;
              done      <= 1'b1;
              note_code <= '0;
            end else begin
              wait_q <= wait_q + WaitW'(1);
            end
          end
          StPlay: begin
            if (!pause) begin
              if (rem_q <= TickW'(1)) begin
                state_q <= StFetch;
                // Request is issued on entry so it lines up with the FETCH cycle.
                if (note_idx < song_len) begin
                  note_idx    <= idx_inc[DEPTH_BIT-1:0];
                  mem_read_en <= (idx_inc < {1'b0, song_len});
                end
              end else begin
                rem_q <= rem_q - TickW'(1);
              end
            end
          end
          StDone: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random songs, checked against event timing and
// per-note sounding-cycle counts derived arithmetically from the note words.
module tb_note_sequencer;

  localparam int Unit    = 8;
  localparam int Gap     = 2;
  localparam int Timeout = 16;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, mem_ready;
  logic [1:0] tempo_sel;
  logic [7:0] song_len, mem_data;
  logic       mem_read_en, mem_read_rst, note_valid, playing, done;
  logic [4:0] note_code;
  logic [7:0] note_idx;
  logic       g_read_en, g_read_rst, g_valid, g_playing, g_done;
  logic [4:0] g_code;
  logic [7:0] g_idx;

  note_sequencer #(.UNIT_TICKS(Unit), .GAP_TICKS(0), .READ_TIMEOUT(Timeout)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .tempo_sel(tempo_sel),
    .song_len(song_len), .mem_data(mem_data), .mem_ready(mem_ready),
    .mem_read_en(mem_read_en), .mem_read_rst(mem_read_rst), .note_code(note_code),
    .note_valid(note_valid), .note_idx(note_idx), .playing(playing), .done(done)
  );

  note_sequencer #(.UNIT_TICKS(Unit), .GAP_TICKS(Gap), .READ_TIMEOUT(Timeout)) dut_gap (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .tempo_sel(tempo_sel),
    .song_len(song_len), .mem_data(mem_data), .mem_ready(mem_ready),
    .mem_read_en(g_read_en), .mem_read_rst(g_read_rst), .note_code(g_code),
    .note_valid(g_valid), .note_idx(g_idx), .playing(g_playing), .done(g_done)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] song [8];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_song();
    for (int i = 0; i < 8; i++) song[i] = 8'h00;
  endtask

  // Plays one song; dfix>0 fixes the read latency, drop_r names a read that never gets mem_ready,
  // p_len<0 picks a random pause burst per note, stop_off>=0 aborts that many cycles after start.
  task automatic run_song(input int slen, input int tempo, input int dfix, input int drop_r,
                          input int p_len, input int p_off, input int stop_off);
    int exp_read, exp_done, reads, rsts, r_at, start_cyc, stop_cyc, p_from, p_to;
    int d, t, p, po, u;
    bit stopped, got_done;
    logic [7:0] w;
    int vexp [8];
    int vexp_g [8];
    int vcnt [8];
    int vcnt_g [8];
    for (int i = 0; i < 8; i++) begin
      vexp[i] = 0; vexp_g[i] = 0; vcnt[i] = 0; vcnt_g[i] = 0;
    end
    reads = 0; rsts = 0; r_at = -1; stop_cyc = -1; p_from = -1; p_to = -2;
    stopped = 1'b0; got_done = 1'b0;
    song_len  = 8'(slen);
    tempo_sel = 2'(tempo);
    start_cyc = cyc;
    start     = 1'b1;
    exp_read  = (slen != 0) ? cyc + 2 : -1;
    exp_done  = (slen != 0) ? -1 : cyc + 3;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (stopped) begin
        check("stop_quiet", int'({done, mem_read_en, mem_read_rst, playing, note_valid}), 0);
        check("stop_code", int'(note_code), 0);
        start = 1'b0; stop = 1'b0; pause = 1'b0; mem_ready = 1'b0;
        if (cyc >= stop_cyc + 6) break;
        continue;
      end
      if (mem_read_rst) begin
        rsts++;
        check("rst_time", cyc, start_cyc + 1);
      end
      if (pause) begin
        check("pause_mute", int'(note_valid), 0);
        check("pause_mute_g", int'(g_valid), 0);
      end
      if (note_valid) begin
        check("pitch", int'(note_code), (note_idx < 8) ? int'(song[note_idx[2:0]][7:3]) : -1);
        if (note_idx < 8) vcnt[note_idx[2:0]]++;
      end
      if (g_valid) begin
        check("pitch_g", int'(g_code), (g_idx < 8) ? int'(song[g_idx[2:0]][7:3]) : -1);
        if (g_idx < 8) vcnt_g[g_idx[2:0]]++;
      end
      if (mem_read_en) begin
        check("read_time", cyc, exp_read);
        check("read_idx", int'(note_idx), reads);
        d = (dfix > 0) ? dfix : int'($urandom_range(3, 1));
        w = song[3'(reads)];
        mem_data = w;
        exp_read = -1;
        exp_done = -1;
        if (reads == drop_r) begin
          exp_done = cyc + 1 + Timeout;
        end else begin
          r_at = cyc + d;
          if (w == 8'h00) begin
            exp_done = r_at + 1;
          end else begin
            u  = (w[2:0] == 3'd0) ? 8 : int'(w[2:0]);
            t  = (Unit >> tempo) * u;
            p  = (p_len >= 0) ? p_len : int'($urandom_range(3, 0));
            po = (p_off < t) ? p_off : t - 1;
            p_from = r_at + 1 + po;
            p_to   = r_at + po + p;
            if (w[7:3] != 5'd0) begin
              vexp[3'(reads)]   = t;
              vexp_g[3'(reads)] = (t > Gap) ? t - Gap : 0;
            end
            if (reads + 1 < slen) exp_read = r_at + 1 + t + p;
            else                  exp_done = r_at + 2 + t + p;
          end
        end
        reads++;
      end
      if (done) begin
        got_done = 1'b1;
        check("done_time", cyc, exp_done);
        check("done_code", int'(note_code), 0);
        check("done_valid", int'(note_valid), 0);
        break;
      end
      // A second start mid-song must be ignored.
      start     = (cyc == start_cyc + 5);
      mem_ready = (cyc == r_at);
      pause     = (cyc >= p_from && cyc <= p_to);
      stop      = (stop_off >= 0 && cyc == start_cyc + stop_off);
      if (stop) begin
        stopped  = 1'b1;
        stop_cyc = cyc;
      end
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; mem_ready = 1'b0;
    if (!stopped) begin
      check("got_done", int'(got_done), 1);
      check("rst_pulses", rsts, 1);
      step();
      check("idle_after", int'(playing), 0);
      for (int i = 0; i < 8; i++) begin
        check("valid_cycles", vcnt[i], vexp[i]);
        check("valid_cycles_g", vcnt_g[i], vexp_g[i]);
      end
    end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; pause = 1'b0; tempo_sel = 2'd0;
    song_len = 8'd0; mem_data = 8'h00; mem_ready = 1'b0;
    clear_song();
    repeat (3) step();
    check("rst_flags", int'({mem_read_en, mem_read_rst, note_valid, playing, done}), 0);
    check("rst_code", int'(note_code), 0);
    check("rst_idx", int'(note_idx), 0);
    check("rst_flags_g", int'({g_read_en, g_read_rst, g_valid, g_playing, g_done}), 0);
    rst = 1'b0; start = 1'b0;
    repeat (2) step();
    check("idle_hold", int'({playing, mem_read_rst, mem_read_en}), 0);

    song[0] = 8'h0A;
    run_song(3, 0, 1, -1, 0, 0, -1);
    clear_song(); song[0] = 8'h11; song[1] = 8'h21;
    run_song(2, 1, 1, -1, 0, 0, -1);
    clear_song(); song[0] = 8'h03;
    run_song(1, 0, 1, -1, 0, 0, -1);
    clear_song(); song[0] = 8'h0A;
    run_song(1, 0, 1, -1, 5, 4, -1);
    song[1] = 8'h0A;
    run_song(2, 0, 1, -1, 0, 0, 6);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start_stop", int'({playing, mem_read_rst}), 0);
    step();
    check("start_stop_hold", int'({playing, mem_read_en}), 0);
    run_song(2, 0, 1, 0, 0, 0, -1);
    run_song(0, 0, 1, -1, 0, 0, -1);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 8; i++) song[i] = 8'($urandom);
      if ($urandom_range(5, 0) == 0) song[3'($urandom_range(7, 0))] = 8'h00;
      run_song(int'($urandom_range(6, 0)), int'($urandom_range(3, 0)), 0,
               ($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 0)) : -1,
               -1, int'($urandom_range(6, 0)),
               ($urandom_range(5, 0) == 0) ? int'($urandom_range(40, 1)) : -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
